// File: rtl/axi_read_arbiter.sv
// Two-master / one-slave AXI4 read arbiter with one outstanding burst and rlast/arlen beat checking.
// Define ARB_ROUND_ROBIN_EN to alternate tie priority; otherwise master 1 always wins ties.
module axi_read_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4,
   parameter int LEN_W  = 8
) (
   input  logic              i_clock,
   input  logic              i_reset,
   // master 0
   input  logic [ADDR_W-1:0] i_m0_araddr,
   input  logic              i_m0_arvalid,
   output logic              o_m0_arready,
   input  logic [ID_W-1:0]   i_m0_arid,
   input  logic [LEN_W-1:0]  i_m0_arlen,
   input  logic [2:0]        i_m0_arsize,
   input  logic [1:0]        i_m0_arburst,
   output logic [DATA_W-1:0] o_m0_rdata,
   output logic [1:0]        o_m0_rresp,
   output logic              o_m0_rvalid,
   output logic              o_m0_rlast,
   output logic [ID_W-1:0]   o_m0_rid,
   input  logic              i_m0_rready,
   // master 1
   input  logic [ADDR_W-1:0] i_m1_araddr,
   input  logic              i_m1_arvalid,
   output logic              o_m1_arready,
   input  logic [ID_W-1:0]   i_m1_arid,
   input  logic [LEN_W-1:0]  i_m1_arlen,
   input  logic [2:0]        i_m1_arsize,
   input  logic [1:0]        i_m1_arburst,
   output logic [DATA_W-1:0] o_m1_rdata,
   output logic [1:0]        o_m1_rresp,
   output logic              o_m1_rvalid,
   output logic              o_m1_rlast,
   output logic [ID_W-1:0]   o_m1_rid,
   input  logic              i_m1_rready,
   // slave
   output logic [ADDR_W-1:0] o_s_araddr,
   output logic              o_s_arvalid,
   output logic [ID_W-1:0]   o_s_arid,
   output logic [LEN_W-1:0]  o_s_arlen,
   output logic [2:0]        o_s_arsize,
   output logic [1:0]        o_s_arburst,
   input  logic              i_s_arready,
   input  logic [DATA_W-1:0] i_s_rdata,
   input  logic [1:0]        i_s_rresp,
   input  logic              i_s_rvalid,
   input  logic              i_s_rlast,
   input  logic [ID_W-1:0]   i_s_rid,
   output logic              o_s_rready,
   // status
   output logic [1:0]        o_grant,
   output logic              o_beat_err
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   localparam logic [LEN_W-1:0] CNT_MAX = {LEN_W{1'b1}};

   state_t           state_reg, state_next;
   logic [1:0]       grant_reg, grant_next;
   logic [LEN_W-1:0] beat_cnt_reg, beat_cnt_next;
   logic [LEN_W-1:0] beat_limit_reg, beat_limit_next;
   logic             beat_err_reg, beat_err_next;
`ifdef ARB_ROUND_ROBIN_EN
   logic             last_owner_reg, last_owner_next;
`endif

   logic             pick_m1;
   logic             g_arvalid;
   logic [LEN_W-1:0] g_arlen;
   logic             g_rready;
   logic             beat;

   // Tie-break between simultaneous requests.
   always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
      if (i_m0_arvalid && i_m1_arvalid)
         pick_m1 = ~last_owner_reg;
      else
         pick_m1 = i_m1_arvalid;
`else
      pick_m1 = i_m1_arvalid;
`endif
   end

   // Signals of whichever master currently holds the grant.
   always_comb begin
      g_arvalid = 1'b0;
      g_arlen   = '0;
      g_rready  = 1'b0;
      if (grant_reg[1]) begin
         g_arvalid = i_m1_arvalid;
         g_arlen   = i_m1_arlen;
         g_rready  = i_m1_rready;
      end else if (grant_reg[0]) begin
         g_arvalid = i_m0_arvalid;
         g_arlen   = i_m0_arlen;
         g_rready  = i_m0_rready;
      end
   end

   assign beat = (state_reg == DATA) && i_s_rvalid && g_rready;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state_reg      <= IDLE;
         grant_reg      <= 2'b00;
         beat_cnt_reg   <= '0;
         beat_limit_reg <= '0;
         beat_err_reg   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_owner_reg <= 1'b1;
`endif
      end else begin
         state_reg      <= state_next;
         grant_reg      <= grant_next;
         beat_cnt_reg   <= beat_cnt_next;
         beat_limit_reg <= beat_limit_next;
         beat_err_reg   <= beat_err_next;
`ifdef ARB_ROUND_ROBIN_EN
         last_owner_reg <= last_owner_next;
`endif
      end
   end

   always_comb begin
      state_next      = state_reg;
      grant_next      = grant_reg;
      beat_cnt_next   = beat_cnt_reg;
      beat_limit_next = beat_limit_reg;
      beat_err_next   = beat_err_reg;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner_next = last_owner_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (i_m0_arvalid || i_m1_arvalid) begin
               grant_next = {pick_m1, ~pick_m1};
               state_next = ADDR;
            end
         end
         ADDR: begin
            // A master withdrawing arvalid before acceptance loses its grant.
            if (!g_arvalid) begin
               grant_next = 2'b00;
               state_next = IDLE;
            end else if (i_s_arready) begin
               beat_limit_next = g_arlen;
               beat_cnt_next   = '0;
               state_next      = DATA;
            end
         end
         DATA: begin
            if (beat) begin
               if (beat_cnt_reg != CNT_MAX)
                  beat_cnt_next = beat_cnt_reg + 1'b1;
               if (i_s_rlast) begin
                  if (beat_cnt_reg != beat_limit_reg)
                     beat_err_next = 1'b1;
                  grant_next = 2'b00;
                  state_next = IDLE;
`ifdef ARB_ROUND_ROBIN_EN
                  last_owner_next = grant_reg[1];
`endif
               end else if (beat_cnt_reg == beat_limit_reg) begin
                  // Final expected beat came without rlast; keep waiting for it.
                  beat_err_next = 1'b1;
               end
            end
         end
         default: begin
            grant_next = 2'b00;
            state_next = IDLE;
         end
      endcase
   end

   always_comb begin
      o_m0_arready = 1'b0;
      o_m1_arready = 1'b0;
      o_s_arvalid  = 1'b0;
      o_s_araddr   = '0;
      o_s_arid     = '0;
      o_s_arlen    = '0;
      o_s_arsize   = '0;
      o_s_arburst  = '0;
      o_m0_rdata   = '0;
      o_m0_rresp   = '0;
      o_m0_rvalid  = 1'b0;
      o_m0_rlast   = 1'b0;
      o_m0_rid     = '0;
      o_m1_rdata   = '0;
      o_m1_rresp   = '0;
      o_m1_rvalid  = 1'b0;
      o_m1_rlast   = 1'b0;
      o_m1_rid     = '0;
      o_s_rready   = 1'b0;
      if (state_reg == ADDR) begin
         o_s_arvalid = g_arvalid;
         if (grant_reg[1]) begin
            o_m1_arready = i_s_arready;
            o_s_araddr   = i_m1_araddr;
            o_s_arid     = i_m1_arid;
            o_s_arlen    = i_m1_arlen;
            o_s_arsize   = i_m1_arsize;
            o_s_arburst  = i_m1_arburst;
         end else if (grant_reg[0]) begin
            o_m0_arready = i_s_arready;
            o_s_araddr   = i_m0_araddr;
            o_s_arid     = i_m0_arid;
            o_s_arlen    = i_m0_arlen;
            o_s_arsize   = i_m0_arsize;
            o_s_arburst  = i_m0_arburst;
         end
      end
      if (state_reg == DATA) begin
         o_s_rready = g_rready;
         if (grant_reg[1]) begin
            o_m1_rdata  = i_s_rdata;
            o_m1_rresp  = i_s_rresp;
            o_m1_rvalid = i_s_rvalid;
            o_m1_rlast  = i_s_rlast;
            o_m1_rid    = i_s_rid;
         end else if (grant_reg[0]) begin
            o_m0_rdata  = i_s_rdata;
            o_m0_rresp  = i_s_rresp;
            o_m0_rvalid = i_s_rvalid;
            o_m0_rlast  = i_s_rlast;
            o_m0_rid    = i_s_rid;
         end
      end
   end

   assign o_grant    = grant_reg;
   assign o_beat_err = beat_err_reg;

endmodule
